// File: rtl/text_console_writer_if.sv
// Character stream and framebuffer write port shared between a text producer
// and the console writer.
interface text_console_writer_if;
  logic        char_valid;
  logic        char_ready;
  logic [7:0]  char_data;
  logic [11:0] fg_color;
  logic [11:0] bg_color;
  logic [12:0] write_addr;
  logic [31:0] write_value;
  logic        write_enable;

  modport master (
    output char_valid, char_data, fg_color, bg_color,
    input  char_ready, write_addr, write_value, write_enable
  );

  modport slave (
    input  char_valid, char_data, fg_color, bg_color,
    output char_ready, write_addr, write_value, write_enable
  );
endinterface

// File: rtl/text_console_writer.sv
// Cursor-tracking text writer for the 160x45 cell framebuffer; scrolls by
// rotating v_offset and blanking the newly exposed physical row.
module text_console_writer #(
  parameter int         COLS           = 160,
  parameter int         ROWS           = 45,
  parameter logic [7:0] BLANK_GLYPH    = 8'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  text_console_writer_if.slave  bus,
  output logic [5:0]            v_offset,
  output logic [7:0]            cursor_col,
  output logic [5:0]            cursor_row
);

  localparam logic [12:0] CELLS     = 13'(COLS * ROWS);
  localparam logic [12:0] COLS_W    = 13'(COLS);
  localparam logic [7:0]  COLS_M1   = 8'(COLS - 1);
  localparam logic [5:0]  ROWS_M1   = 6'(ROWS - 1);

  localparam logic [7:0]  CODE_BS   = 8'h08;
  localparam logic [7:0]  CODE_LF   = 8'h0A;
  localparam logic [7:0]  CODE_FF   = 8'h0C;
  localparam logic [7:0]  CODE_CR   = 8'h0D;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CLEAR_LINE   = 2'd1,
    CLEAR_SCREEN = 2'd2
  } state_t;

  state_t      state_r;
  logic [12:0] clr_cnt_r;
  logic [12:0] line_base_r;
  logic [11:0] clr_fg_r;
  logic [11:0] clr_bg_r;

  logic [12:0] cur_addr_s;
  logic [12:0] top_base_s;
  logic [5:0]  v_next_s;
  logic        accept_s;

  // Screen row is rotated by v_offset onto the physical framebuffer row.
  function automatic logic [12:0] cell_addr(input logic [5:0] row,
                                            input logic [5:0] voff,
                                            input logic [7:0] col);
    logic [6:0] sum;
    logic [5:0] phys;
    sum = {1'b0, row} + {1'b0, voff};
    if (sum >= 7'(ROWS)) begin
      phys = 6'(sum - 7'(ROWS));
    end else begin
      phys = sum[5:0];
    end
    return ({7'd0, phys} * COLS_W) + {5'd0, col};
  endfunction

  // Cursor address, scroll target row and acceptance strobe.
  always_comb begin
    cur_addr_s = cell_addr(cursor_row, v_offset, cursor_col);
    top_base_s = {7'd0, v_offset} * COLS_W;
    accept_s   = bus.char_valid && bus.char_ready;
    if (v_offset == ROWS_M1) begin
      v_next_s = 6'd0;
    end else begin
      v_next_s = v_offset + 6'd1;
    end
  end

  // Control FSM: character interpretation, line clear and screen clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= CLEAR_ON_RESET ? CLEAR_SCREEN : IDLE;
      clr_cnt_r        <= 13'd0;
      line_base_r      <= 13'd0;
      clr_fg_r         <= 12'd0;
      clr_bg_r         <= 12'd0;
      bus.char_ready   <= 1'b0;
      bus.write_enable <= 1'b0;
      bus.write_addr   <= 13'd0;
      bus.write_value  <= 32'd0;
      v_offset         <= 6'd0;
      cursor_col       <= 8'd0;
      cursor_row       <= 6'd0;
    end else begin
      case (state_r)
        IDLE: begin
          bus.write_enable <= 1'b0;
          bus.char_ready   <= 1'b1;
          if (accept_s) begin
            case (bus.char_data)
              CODE_CR: begin
                cursor_col <= 8'd0;
              end
              CODE_BS: begin
                if (cursor_col != 8'd0) begin
                  cursor_col <= cursor_col - 8'd1;
                end else begin
                  cursor_col <= cursor_col;
                end
              end
              CODE_LF: begin
                cursor_col <= 8'd0;
                if (cursor_row < ROWS_M1) begin
                  cursor_row <= cursor_row + 6'd1;
                end else begin
                  // First blank cell goes out with the scroll itself.
                  v_offset         <= v_next_s;
                  clr_fg_r         <= bus.fg_color;
                  clr_bg_r         <= bus.bg_color;
                  line_base_r      <= top_base_s;
                  clr_cnt_r        <= 13'd1;
                  bus.write_enable <= 1'b1;
                  bus.write_addr   <= top_base_s;
                  bus.write_value  <= {bus.fg_color, bus.bg_color, BLANK_GLYPH};
                  bus.char_ready   <= 1'b0;
                  state_r          <= CLEAR_LINE;
                end
              end
              CODE_FF: begin
                v_offset         <= 6'd0;
                cursor_col       <= 8'd0;
                cursor_row       <= 6'd0;
                clr_fg_r         <= bus.fg_color;
                clr_bg_r         <= bus.bg_color;
                clr_cnt_r        <= 13'd1;
                bus.write_enable <= 1'b1;
                bus.write_addr   <= 13'd0;
                bus.write_value  <= {bus.fg_color, bus.bg_color, BLANK_GLYPH};
                bus.char_ready   <= 1'b0;
                state_r          <= CLEAR_SCREEN;
              end
              default: begin
                bus.write_enable <= 1'b1;
                bus.write_addr   <= cur_addr_s;
                bus.write_value  <= {bus.fg_color, bus.bg_color, bus.char_data};
                if (cursor_col < COLS_M1) begin
                  cursor_col <= cursor_col + 8'd1;
                end else begin
                  cursor_col <= 8'd0;
                  if (cursor_row < ROWS_M1) begin
                    cursor_row <= cursor_row + 6'd1;
                  end else begin
                    // Character write occupies this cycle; the clear follows.
                    v_offset       <= v_next_s;
                    clr_fg_r       <= bus.fg_color;
                    clr_bg_r       <= bus.bg_color;
                    line_base_r    <= top_base_s;
                    clr_cnt_r      <= 13'd0;
                    bus.char_ready <= 1'b0;
                    state_r        <= CLEAR_LINE;
                  end
                end
              end
            endcase
          end else begin
            state_r <= IDLE;
          end
        end
        CLEAR_LINE: begin
          if (clr_cnt_r == COLS_W) begin
            bus.write_enable <= 1'b0;
            bus.char_ready   <= 1'b1;
            state_r          <= IDLE;
          end else begin
            bus.write_enable <= 1'b1;
            bus.write_addr   <= line_base_r + clr_cnt_r;
            bus.write_value  <= {clr_fg_r, clr_bg_r, BLANK_GLYPH};
            bus.char_ready   <= 1'b0;
            clr_cnt_r        <= clr_cnt_r + 13'd1;
          end
        end
        CLEAR_SCREEN: begin
          if (clr_cnt_r == CELLS) begin
            bus.write_enable <= 1'b0;
            bus.char_ready   <= 1'b1;
            state_r          <= IDLE;
          end else begin
            bus.write_enable <= 1'b1;
            bus.write_addr   <= clr_cnt_r;
            bus.write_value  <= {clr_fg_r, clr_bg_r, BLANK_GLYPH};
            bus.char_ready   <= 1'b0;
            clr_cnt_r        <= clr_cnt_r + 13'd1;
          end
        end
        default: begin
          bus.write_enable <= 1'b0;
          bus.char_ready   <= 1'b0;
          state_r          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: reset clear, printing, control codes,
// both scroll triggers, form feed and reset during a screen clear.
module tb_text_console_writer;

  logic       clk;
  logic       rst_n;
  logic [5:0] v_offset;
  logic [7:0] cursor_col;
  logic [5:0] cursor_row;
  int         vectors;
  int         miscompares;

  text_console_writer_if bus ();

  text_console_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .v_offset   (v_offset),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns in the cycle after acceptance, where any resulting write is visible.
  task automatic send(input logic [7:0] c, input logic [11:0] fg, input logic [11:0] bg);
    int waited;
    waited = 0;
    while (bus.char_ready !== 1'b1 && waited < 20000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 20000) check("ready_timeout", {31'd0, bus.char_ready}, 32'd1);
    bus.char_valid = 1'b1;
    bus.char_data  = c;
    bus.fg_color   = fg;
    bus.bg_color   = bg;
    @(posedge clk); #1;
    bus.char_valid = 1'b0;
  endtask

  // Checks n consecutive blanking writes starting in the current cycle.
  task automatic check_stream(input string tag, input int base, input int n,
                              input logic [11:0] fg, input logic [11:0] bg);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.write_enable !== 1'b1 || bus.write_addr !== 13'(base + i) ||
          bus.write_value !== {fg, bg, 8'h20} || bus.char_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check({tag, "_cells"}, 32'(bad), 32'd0);
    check({tag, "_end_we"}, {31'd0, bus.write_enable}, 32'd0);
    check({tag, "_end_ready"}, {31'd0, bus.char_ready}, 32'd1);
  endtask

  initial begin
    int bad;
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.fg_color   = 12'h000;
    bus.bg_color   = 12'h000;

    repeat (3) @(posedge clk);
    #1;
    check("rst_we", {31'd0, bus.write_enable}, 32'd0);
    check("rst_addr", {19'd0, bus.write_addr}, 32'd0);
    check("rst_value", bus.write_value, 32'd0);
    check("rst_ready", {31'd0, bus.char_ready}, 32'd0);
    check("rst_cursor", {18'd0, cursor_row, cursor_col}, 32'd0);
    check("rst_voff", {26'd0, v_offset}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_stream("boot_clear", 0, 7200, 12'h000, 12'h000);
    check("boot_voff", {26'd0, v_offset}, 32'd0);

    send(8'h41, 12'hFFF, 12'h00F);
    check("A_we", {31'd0, bus.write_enable}, 32'd1);
    check("A_addr", {19'd0, bus.write_addr}, 32'd0);
    check("A_value", bus.write_value, 32'hFFF00F41);
    check("A_col", {24'd0, cursor_col}, 32'd1);

    send(8'h0D, 12'h000, 12'h000);
    check("cr_we", {31'd0, bus.write_enable}, 32'd0);
    check("cr_col", {24'd0, cursor_col}, 32'd0);

    bad = 0;
    for (int i = 0; i < 160; i++) begin
      send(8'h78, 12'h0AA, 12'h055);
      if (bus.write_enable !== 1'b1 || bus.write_addr !== 13'(i) ||
          bus.write_value !== 32'h0AA05578) bad++;
    end
    check("row0_cells", 32'(bad), 32'd0);
    check("row0_last_addr", {19'd0, bus.write_addr}, 32'd159);
    check("row0_cursor", {18'd0, cursor_row, cursor_col}, {18'd0, 6'd1, 8'd0});
    send(8'h79, 12'h0AA, 12'h055);
    check("row1_addr", {19'd0, bus.write_addr}, 32'd160);

    send(8'h0D, 12'h000, 12'h000);
    send(8'h08, 12'h000, 12'h000);
    check("bs0_we", {31'd0, bus.write_enable}, 32'd0);
    check("bs0_cursor", {18'd0, cursor_row, cursor_col}, {18'd0, 6'd1, 8'd0});
    send(8'h71, 12'h0AA, 12'h055);
    check("q_addr", {19'd0, bus.write_addr}, 32'd160);
    send(8'h08, 12'h000, 12'h000);
    check("bs1_we", {31'd0, bus.write_enable}, 32'd0);
    check("bs1_col", {24'd0, cursor_col}, 32'd0);

    for (int i = 0; i < 43; i++) send(8'h0A, 12'h000, 12'h000);
    check("lf_row44", {26'd0, cursor_row}, 32'd44);
    check("lf_row44_voff", {26'd0, v_offset}, 32'd0);

    send(8'h0A, 12'hABC, 12'h123);
    check("scroll1_voff", {26'd0, v_offset}, 32'd1);
    check("scroll1_cursor", {18'd0, cursor_row, cursor_col}, {18'd0, 6'd44, 8'd0});
    check_stream("scroll1", 0, 160, 12'hABC, 12'h123);
    send(8'h42, 12'hFFF, 12'h000);
    check("B_addr", {19'd0, bus.write_addr}, 32'd0);
    check("B_value", bus.write_value, 32'hFFF00042);

    for (int i = 0; i < 42; i++) send(8'h0A, 12'h000, 12'h000);
    check("voff43", {26'd0, v_offset}, 32'd43);
    send(8'h0D, 12'h000, 12'h000);
    for (int i = 0; i < 159; i++) send(8'h7A, 12'h000, 12'hFFF);
    check("col159", {24'd0, cursor_col}, 32'd159);
    send(8'h45, 12'h321, 12'h654);
    check("pscroll_char_addr", {19'd0, bus.write_addr}, 32'd6879);
    check("pscroll_char_value", bus.write_value, 32'h32165445);
    check("pscroll_voff", {26'd0, v_offset}, 32'd44);
    check("pscroll_cursor", {18'd0, cursor_row, cursor_col}, {18'd0, 6'd44, 8'd0});
    check("pscroll_ready", {31'd0, bus.char_ready}, 32'd0);
    @(posedge clk); #1;
    check_stream("pscroll", 6880, 160, 12'h321, 12'h654);

    send(8'h0A, 12'h000, 12'h777);
    check("wrap_voff", {26'd0, v_offset}, 32'd0);
    check_stream("wrap", 7040, 160, 12'h000, 12'h777);
    send(8'h4D, 12'h111, 12'h222);
    check("M_addr", {19'd0, bus.write_addr}, 32'd7040);

    send(8'h0C, 12'h0F0, 12'h111);
    check("ff_cursor", {18'd0, cursor_row, cursor_col}, 32'd0);
    check("ff_voff", {26'd0, v_offset}, 32'd0);
    check_stream("ff", 0, 7200, 12'h0F0, 12'h111);

    send(8'h0C, 12'h0F0, 12'h111);
    repeat (50) @(posedge clk);
    #1;
    check("midclr_we", {31'd0, bus.write_enable}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_we", {31'd0, bus.write_enable}, 32'd0);
    check("abort_ready", {31'd0, bus.char_ready}, 32'd0);
    check("abort_addr", {19'd0, bus.write_addr}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reboot_we", {31'd0, bus.write_enable}, 32'd1);
    check("reboot_addr", {19'd0, bus.write_addr}, 32'd0);
    check("reboot_value", bus.write_value, 32'h00000020);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
